// File: rtl/miriscv_irq_ctrl.sv
// -----------------------------------------------------------------------------
// miriscv_irq_ctrl
//
// Edge-triggered interrupt controller for a single-hart core without nesting.
// Rising edges on the request lines are latched into a pending register. The
// lowest-index pending line that is enabled is presented to the core. The
// presented line is held until the core acknowledges it (trap entry) or until
// its enable is withdrawn. An acknowledged line stays in service until mret,
// and its pending bit is cleared at that point.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   irq_req_i      interrupt request lines (rising-edge sensitive)
//   mie_i          per-line enable mask
//   mstatus_mie_i  global interrupt enable
//   irq_ack_i      core entered the trap for the presented interrupt
//   irq_ret_i      core executed mret
//   irq_o          interrupt request to the core (registered)
//   irq_id_o       index of the presented / in-service line
//   irq_cause_o    mcause value for irq_id_o
//   irq_pend_o     pending register contents
// -----------------------------------------------------------------------------
module miriscv_irq_ctrl #(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               mstatus_mie_i,
    input  logic               irq_ack_i,
    input  logic               irq_ret_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_pend_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [4:0]         id_q, id_d;
    logic               irq_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] id_oh;
    logic [NUM_IRQ-1:0] pend_clr;
    logic               sel_valid;
    logic [4:0]         sel_id;
    logic               cur_enabled;

    assign rise     = irq_req_i & ~req_q;
    assign eligible = pend_q & mie_i;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_valid = 1'b1;
                sel_id    = 5'(i);
            end
        end
    end

    // One-hot form of id_q avoids indexing mie_i/pend with an id that could
    // exceed the line count when NUM_IRQ < 32.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            id_oh[i] = (id_q == 5'(i));
        end
    end

    assign cur_enabled = |(id_oh & mie_i);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        pend_clr = '0;
        case (state_q)
            IDLE: begin
                if (mstatus_mie_i && sel_valid) begin
                    state_d = REQ;
                    id_d    = sel_id;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over a simultaneous withdraw.
                if (irq_ack_i) begin
                    state_d = SERVE;
                end else if (!cur_enabled || !mstatus_mie_i) begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (irq_ret_i) begin
                    state_d  = IDLE;
                    pend_clr = id_oh;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A new rise wins over a clear landing on the same bit.
    assign pend_d = (pend_q & ~pend_clr) | rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            id_q    <= 5'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= irq_req_i;
            pend_q  <= pend_d;
            id_q    <= id_d;
            irq_q   <= (state_d == REQ);
        end
    end

    assign irq_o       = irq_q;
    assign irq_id_o    = id_q;
    assign irq_cause_o = {1'b1, 26'd0, id_q};
    assign irq_pend_o  = pend_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_miriscv_irq_ctrl
//
// Self-checking bench for miriscv_irq_ctrl (NUM_IRQ = 32): a table of
// single-cycle vectors, hand-written multi-cycle scenarios, and a randomized
// run compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_miriscv_irq_ctrl;

    localparam int          N    = 32;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  mie;
    logic          gmie;
    logic          ack;
    logic          ret;
    logic          irq;
    logic [4:0]    id;
    logic [31:0]   cause;
    logic [N-1:0]  pend;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    miriscv_irq_ctrl #(.NUM_IRQ(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .irq_req_i     (req),
        .mie_i         (mie),
        .mstatus_mie_i (gmie),
        .irq_ack_i     (ack),
        .irq_ret_i     (ret),
        .irq_o         (irq),
        .irq_id_o      (id),
        .irq_cause_o   (cause),
        .irq_pend_o    (pend)
    );

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic [31:0] mie;
        logic        gmie;
        logic        ack;
        logic        ret;
        logic        eirq;
        logic [4:0]  eid;
        logic [31:0] epend;
    } vec_t;

    vec_t tbl [15];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic eirq, input logic [4:0] eid,
                              input logic [31:0] epend);
        logic [31:0] ecause;
        ecause = {1'b1, 26'd0, eid};
        check32({name, "_irq"},   32'(irq), 32'(eirq));
        check32({name, "_id"},    32'(id),  32'(eid));
        check32({name, "_cause"}, cause,    ecause);
        check32({name, "_pend"},  pend,     epend);
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic r, input logic [31:0] q, input logic [31:0] m,
                       input logic g, input logic a, input logic t);
        rst  = r;
        req  = q;
        mie  = m;
        gmie = g;
        ack  = a;
        ret  = t;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state
    bit [31:0] m_pend;
    bit [31:0] m_prev;
    bit        m_pres;
    bit        m_serv;
    int        m_id;

    initial begin
        rst = 1'b1; req = '0; mie = '0; gmie = 1'b0; ack = 1'b0; ret = 1'b0;

        // ---------------- table-driven vectors: basic flow on line 1 ----------
        //            rst req  mie  g  a  t   irq id pend
        tbl[0]  = '{1, 32'h0, 32'h2, 1, 0, 0,  0, 0, 32'h0};
        tbl[1]  = '{0, 32'h2, 32'h2, 1, 0, 0,  0, 0, 32'h2};
        tbl[2]  = '{0, 32'h0, 32'h2, 1, 0, 0,  1, 1, 32'h2};
        tbl[3]  = '{0, 32'h0, 32'h2, 1, 1, 0,  0, 1, 32'h2};
        tbl[4]  = '{0, 32'h0, 32'h2, 1, 0, 0,  0, 1, 32'h2};
        tbl[5]  = '{0, 32'h0, 32'h2, 1, 0, 1,  0, 1, 32'h0};
        tbl[6]  = '{0, 32'h0, 32'h2, 1, 0, 0,  0, 1, 32'h0};
        tbl[7]  = '{0, 32'h0, 32'h2, 1, 1, 0,  0, 1, 32'h0};
        tbl[8]  = '{0, 32'h2, 32'h2, 1, 0, 0,  0, 1, 32'h2};
        tbl[9]  = '{0, 32'h2, 32'h2, 1, 0, 1,  1, 1, 32'h2};
        tbl[10] = '{0, 32'h2, 32'h2, 1, 0, 1,  1, 1, 32'h2};
        tbl[11] = '{0, 32'h2, 32'h2, 1, 1, 0,  0, 1, 32'h2};
        tbl[12] = '{0, 32'h2, 32'h2, 1, 0, 0,  0, 1, 32'h2};
        tbl[13] = '{0, 32'h2, 32'h2, 1, 0, 1,  0, 1, 32'h0};
        tbl[14] = '{0, 32'h2, 32'h2, 1, 0, 0,  0, 1, 32'h0};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].req, tbl[i].mie, tbl[i].gmie, tbl[i].ack, tbl[i].ret);
            expect_out($sformatf("vec%0d", i), tbl[i].eirq, tbl[i].eid, tbl[i].epend);
        end

        // ---------------- priority: lines 5 and 3 together --------------------
        cyc(1, 32'h0,  ONES, 1, 0, 0);
        cyc(0, 32'h28, ONES, 1, 0, 0); expect_out("pri_a", 0, 0, 32'h28);
        cyc(0, 32'h28, ONES, 1, 0, 0); expect_out("pri_b", 1, 3, 32'h28);
        cyc(0, 32'h28, ONES, 1, 1, 0); expect_out("pri_c", 0, 3, 32'h28);
        cyc(0, 32'h28, ONES, 1, 0, 1); expect_out("pri_d", 0, 3, 32'h20);
        cyc(0, 32'h28, ONES, 1, 0, 0); expect_out("pri_e", 1, 5, 32'h20);
        cyc(0, 32'h28, ONES, 1, 1, 0); expect_out("pri_f", 0, 5, 32'h20);
        cyc(0, 32'h28, ONES, 1, 0, 1); expect_out("pri_g", 0, 5, 32'h0);

        // ---------------- mask withdraw on line 4 -----------------------------
        cyc(1, 32'h0,  ONES, 1, 0, 0);
        cyc(0, 32'h10, ONES, 1, 0, 0);           expect_out("wd_a", 0, 0, 32'h10);
        cyc(0, 32'h10, ONES, 1, 0, 0);           expect_out("wd_b", 1, 4, 32'h10);
        cyc(0, 32'h10, ONES & ~32'h10, 1, 0, 0); expect_out("wd_c", 0, 4, 32'h10);
        cyc(0, 32'h10, ONES & ~32'h10, 1, 0, 0); expect_out("wd_d", 0, 4, 32'h10);
        cyc(0, 32'h10, ONES, 1, 0, 0);           expect_out("wd_e", 1, 4, 32'h10);
        cyc(0, 32'h10, ONES, 1, 1, 0);           expect_out("wd_f", 0, 4, 32'h10);
        cyc(0, 32'h10, ONES, 1, 0, 1);           expect_out("wd_g", 0, 4, 32'h0);

        // ---------------- global disable then enable --------------------------
        cyc(1, 32'h0, ONES, 0, 0, 0);
        cyc(0, 32'h1, ONES, 0, 0, 0); expect_out("gd_a", 0, 0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 32'h1, ONES, 0, 0, 0);
            expect_out($sformatf("gd_hold%0d", i), 0, 0, 32'h1);
        end
        cyc(0, 32'h1, ONES, 1, 0, 0); expect_out("gd_b", 1, 0, 32'h1);
        cyc(0, 32'h1, ONES, 1, 1, 0); expect_out("gd_c", 0, 0, 32'h1);
        cyc(0, 32'h1, ONES, 1, 0, 1); expect_out("gd_d", 0, 0, 32'h0);

        // ---------------- level hold and re-edge on line 2 --------------------
        cyc(1, 32'h0, ONES, 1, 0, 0);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("lv_a", 0, 0, 32'h4);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("lv_b", 1, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 1, 0); expect_out("lv_c", 0, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 0, 1); expect_out("lv_d", 0, 2, 32'h0);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("lv_e", 0, 2, 32'h0);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("lv_f", 0, 2, 32'h0);
        cyc(0, 32'h0, ONES, 1, 0, 0); expect_out("re_a", 0, 2, 32'h0);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("re_b", 0, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("re_c", 1, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 1, 0); expect_out("re_d", 0, 2, 32'h4);
        cyc(0, 32'h0, ONES, 1, 0, 0); expect_out("re_e", 0, 2, 32'h4);
        // New rise lands on the same edge as the return: the set must win.
        cyc(0, 32'h4, ONES, 1, 0, 1); expect_out("re_f", 0, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 0, 0); expect_out("re_g", 1, 2, 32'h4);
        cyc(0, 32'h4, ONES, 1, 1, 0); expect_out("re_h", 0, 2, 32'h4);
        cyc(0, 32'h0, ONES, 1, 0, 1); expect_out("re_i", 0, 2, 32'h0);

        // ---------------- reset during service on line 7 ----------------------
        cyc(1, 32'h0,  ONES, 1, 0, 0);
        cyc(0, 32'h80, ONES, 1, 0, 0); expect_out("rs_a", 0, 0, 32'h80);
        cyc(0, 32'h80, ONES, 1, 0, 0); expect_out("rs_b", 1, 7, 32'h80);
        cyc(0, 32'h80, ONES, 1, 1, 0); expect_out("rs_c", 0, 7, 32'h80);
        cyc(1, 32'h80, ONES, 1, 0, 0); expect_out("rs_d", 0, 0, 32'h0);
        cyc(0, 32'h80, ONES, 1, 0, 0); expect_out("rs_e", 0, 0, 32'h80);
        cyc(0, 32'h80, ONES, 1, 0, 0); expect_out("rs_f", 1, 7, 32'h80);

        // ---------------- randomized run against the model --------------------
        begin
            logic [31:0] r_req, r_mie, rise, clr, rnd;
            logic        r_rst, r_g, r_a, r_t;
            bit          n_pres, n_serv;
            r_req = '0;
            for (int c = 0; c < 3000; c++) begin
                rnd   = $urandom;
                r_req = r_req ^ (rnd & (rnd >> 3) & (rnd >> 7) & $urandom);
                r_mie = ($urandom_range(0, 7) == 0) ? $urandom : ONES;
                r_g   = ($urandom_range(0, 9) != 0);
                r_a   = ($urandom_range(0, 2) == 0);
                r_t   = ($urandom_range(0, 3) == 0);
                r_rst = (c == 0) || ($urandom_range(0, 249) == 0);

                rise = r_req & ~m_prev;
                if (r_rst) begin
                    m_pend = '0; m_prev = '0; m_pres = 1'b0; m_serv = 1'b0; m_id = 0;
                end else begin
                    clr    = '0;
                    n_pres = m_pres;
                    n_serv = m_serv;
                    if (m_pres) begin
                        if (r_a) begin
                            n_pres = 1'b0;
                            n_serv = 1'b1;
                        end else if (!r_mie[m_id] || !r_g) begin
                            n_pres = 1'b0;
                        end
                    end else if (m_serv) begin
                        if (r_t) begin
                            clr[m_id] = 1'b1;
                            n_serv    = 1'b0;
                        end
                    end else if (r_g && ((m_pend & r_mie) != 0)) begin
                        for (int k = 31; k >= 0; k--) begin
                            if (m_pend[k] && r_mie[k]) m_id = k;
                        end
                        n_pres = 1'b1;
                    end
                    m_pend = (m_pend & ~clr) | rise;
                    m_prev = r_req;
                    m_pres = n_pres;
                    m_serv = n_serv;
                end

                cyc(r_rst, r_req, r_mie, r_g, r_a, r_t);
                expect_out($sformatf("rnd%0d", c), m_pres, 5'(m_id), m_pend);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
